// File: rtl/blockram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : blockram_arbiter
//  Purpose  : Shares the single read port of a blockram between CLIENTS
//             requesters (round-robin), passes one write client through, and
//             contains a clear sequencer that zeroes every address.
//  Revision : 1.0 - initial release
// ============================================================================
module blockram_arbiter #(
    parameter int WIDTH   = 0,
    parameter int DEPTH   = 1,
    parameter int CLIENTS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CLIENTS-1:0]            rd_req,
    input  logic [CLIENTS*(12+DEPTH)-1:0] rd_addr,
    output logic [CLIENTS-1:0]            rd_gnt,
    output logic [CLIENTS-1:0]            rd_valid,
    output logic [(8<<WIDTH)-1:0]         rd_data,
    input  logic                          wr_req,
    input  logic [(12+DEPTH)-1:0]         wr_addr,
    input  logic [(8<<WIDTH)-1:0]         wr_data,
    output logic                          wr_gnt,
    input  logic                          clr_start,
    output logic                          busy,
    output logic [(12+DEPTH)-1:0]         ram_raddr,
    input  logic [(8<<WIDTH)-1:0]         ram_rval,
    output logic [(12+DEPTH)-1:0]         ram_waddr,
    output logic [(8<<WIDTH)-1:0]         ram_wval,
    output logic                          ram_wenable
);

    localparam int C_AW = 12 + DEPTH;
    localparam int C_PW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

    localparam logic [C_AW-1:0] C_CNT_LAST = {C_AW{1'b1}};

    localparam logic [0:0] C_ST_IDLE  = 1'b0;
    localparam logic [0:0] C_ST_CLEAR = 1'b1;

    logic [0:0]         r_state;
    logic [C_AW-1:0]    r_cnt;
    logic [C_PW-1:0]    r_ptr;
    logic [CLIENTS-1:0] r_valid;
    logic [C_AW-1:0]    r_last_addr;

    logic               w_found;
    logic [C_PW-1:0]    w_gnt_idx;
    logic [C_PW-1:0]    w_cand_idx;
    int                 w_cand;
    logic               w_any;
    logic [C_AW-1:0]    w_sel_addr;

    assign busy = (r_state == C_ST_CLEAR);

    // Round-robin search: first requester upward from the pointer + 1, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = r_ptr;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 1; k <= CLIENTS; k++) begin
            w_cand     = (int'(r_ptr) + k) % CLIENTS;
            w_cand_idx = C_PW'(w_cand);
            if (!w_found && rd_req[w_cand_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand_idx;
            end
        end
    end

    // Grants are suppressed during reset and while the clear owns the RAM.
    assign w_any      = w_found & rst_n & ~busy;
    assign w_sel_addr = rd_addr[w_gnt_idx*C_AW +: C_AW];

    // One-hot grant vector from the winning index.
    always_comb begin
        rd_gnt = '0;
        if (w_any) begin
            rd_gnt[w_gnt_idx] = 1'b1;
        end
    end

    // With no grant the read address parks on the last granted address.
    assign ram_raddr = w_any ? w_sel_addr : r_last_addr;
    assign rd_data   = ram_rval;
    assign rd_valid  = r_valid;

    // Arbitration state and the one-cycle read-return tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= C_PW'(CLIENTS - 1);
            r_last_addr <= '0;
            r_valid     <= '0;
        end else begin
            r_valid <= rd_gnt;
            if (w_any) begin
                r_ptr       <= w_gnt_idx;
                r_last_addr <= w_sel_addr;
            end
        end
    end

    // Clear sequencer: sweeps 0 .. 2^AW-1 once; clr_start while busy is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (clr_start) begin
                        r_state <= C_ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                C_ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign wr_gnt = wr_req & ~busy & rst_n;

    // Write port: the clear sequencer owns it while busy, else the write client.
    always_comb begin
        ram_wenable = wr_gnt;
        ram_waddr   = wr_addr;
        ram_wval    = wr_data;
        if (busy) begin
            ram_wenable = rst_n;
            ram_waddr   = r_cnt;
            ram_wval    = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blockram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blockram_arbiter
//  Purpose  : Self-checking bench for blockram_arbiter (CLIENTS=2, AW=13, DW=8)
//             with a behavioural synchronous-read RAM attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blockram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rd_req;
    logic [25:0] rd_addr;
    logic [1:0]  rd_gnt;
    logic [1:0]  rd_valid;
    logic [7:0]  rd_data;
    logic        wr_req;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_gnt;
    logic        clr_start;
    logic        busy;
    logic [12:0] ram_raddr;
    logic [7:0]  ram_rval;
    logic [12:0] ram_waddr;
    logic [7:0]  ram_wval;
    logic        ram_wenable;

    blockram_arbiter #(.WIDTH(0), .DEPTH(1), .CLIENTS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .clr_start(clr_start), .busy(busy),
        .ram_raddr(ram_raddr), .ram_rval(ram_rval),
        .ram_waddr(ram_waddr), .ram_wval(ram_wval), .ram_wenable(ram_wenable)
    );

    // Behavioural blockram: synchronous write, registered read.
    logic [7:0] mem [8192];
    always @(posedge clk) begin
        if (ram_wenable) mem[ram_waddr] <= ram_wval;
        ram_rval <= mem[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [12:0] a0;
        logic [12:0] a1;
        logic        wreq;
        logic [12:0] wa;
        logic [7:0]  wd;
        logic [1:0]  gnt;
        logic        wgnt;
    } vec_t;

    typedef struct {
        logic [1:0] v;
        logic [7:0] d;
    } sb_t;

    sb_t        sb[$];
    logic [7:0] shadow [8192];
    vec_t       tbl [14];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Pop the expectation pushed one cycle earlier and compare the read return.
    task automatic sb_check(input string name);
        sb_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, rd_valid=%0h expected an entry", name, rd_valid);
        end else begin
            e = sb.pop_front();
            chk({name, "_valid"}, 32'(rd_valid), 32'(e.v));
            if (e.v != 2'b00) chk({name, "_data"}, 32'(rd_data), 32'(e.d));
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [1:0] g, input logic [12:0] a0,
                                            input logic [12:0] a1);
        if (g == 2'b01) return shadow[a0];
        if (g == 2'b10) return shadow[a1];
        return 8'h00;
    endfunction

    // One live cycle: drive just after posedge, check grants at negedge.
    task automatic tick(input string name, input logic [1:0] req, input logic [12:0] a0,
                        input logic [12:0] a1, input logic wreq, input logic [12:0] wa,
                        input logic [7:0] wd, input logic clr, input logic [1:0] egnt,
                        input logic ewgnt);
        sb_t e;
        rd_req    = req;
        rd_addr   = {a1, a0};
        wr_req    = wreq;
        wr_addr   = wa;
        wr_data   = wd;
        clr_start = clr;
        @(negedge clk);
        chk({name, "_rd_gnt"}, 32'(rd_gnt), 32'(egnt));
        chk({name, "_wr_gnt"}, 32'(wr_gnt), 32'(ewgnt));
        sb_check(name);
        e.v = egnt;
        e.d = exp_data(egnt, a0, a1);
        sb.push_back(e);
        if (ewgnt) shadow[wa] = wd;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rd_req    = 2'b11;
        rd_addr   = '0;
        wr_req    = 1'b1;
        wr_addr   = 13'h0;
        wr_data   = 8'h00;
        clr_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rd_gnt", 32'(rd_gnt), 0);
        chk("rst_wr_gnt", 32'(wr_gnt), 0);
        chk("rst_wenable", 32'(ram_wenable), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        sb.push_back('{2'b00, 8'h00});
    endtask

    // Caller has just issued the clr_start cycle. Holds both reads and a write
    // pending through the clear, then checks the first cycle after busy drops.
    task automatic run_clear(input string name, input int restart_at, input int rst_at,
                             input int exp_len, input logic [1:0] exit_gnt);
        int   n_busy = 0;
        int   n_bad_gnt = 0;
        int   n_bad_valid = 0;
        sb_t  e;
        rd_req  = 2'b11;
        rd_addr = {13'h1FFF, 13'h0000};
        wr_req  = 1'b1;
        wr_addr = 13'h0200;
        wr_data = 8'h99;
        for (int c = 0; c < 9000; c++) begin
            clr_start = (c == restart_at);
            rst_n     = (c != rst_at);
            @(negedge clk);
            if (c == 0) sb_check({name, "_first"});
            if (!busy) break;
            n_busy++;
            if (rd_gnt != 2'b00 || wr_gnt != 1'b0) n_bad_gnt++;
            if (c != 0 && rd_valid != 2'b00) n_bad_valid++;
            @(posedge clk); #1;
        end
        clr_start = 1'b0;
        rst_n     = 1'b1;
        chk({name, "_busy_len"}, 32'(n_busy), 32'(exp_len));
        chk({name, "_gnt_while_busy"}, 32'(n_bad_gnt), 0);
        chk({name, "_valid_while_busy"}, 32'(n_bad_valid), 0);
        if (rst_at < 0) begin
            for (int a = 0; a < 8192; a++) shadow[a] = 8'h00;
        end else begin
            for (int a = 0; a < rst_at; a++) shadow[a] = 8'h00;
        end
        chk({name, "_exit_rd_gnt"}, 32'(rd_gnt), 32'(exit_gnt));
        chk({name, "_exit_wr_gnt"}, 32'(wr_gnt), 1);
        e.v = exit_gnt;
        e.d = exp_data(exit_gnt, 13'h0000, 13'h1FFF);
        sb.push_back(e);
        shadow[13'h0200] = 8'h99;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) begin
            mem[a]    = 8'h00;
            shadow[a] = 8'h00;
        end
        //            req    a0        a1        wreq  wa        wd     gnt    wgnt
        tbl[0]  = '{2'b00, 13'h0000, 13'h0000, 1'b1, 13'h0010, 8'hA5, 2'b00, 1'b1};
        tbl[1]  = '{2'b10, 13'h0000, 13'h0010, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};
        tbl[2]  = '{2'b00, 13'h0000, 13'h0000, 1'b1, 13'h0020, 8'h5A, 2'b00, 1'b1};
        tbl[3]  = '{2'b01, 13'h0020, 13'h0000, 1'b0, 13'h0000, 8'h00, 2'b01, 1'b0};
        tbl[4]  = '{2'b11, 13'h0010, 13'h0020, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};
        tbl[5]  = '{2'b11, 13'h0010, 13'h0020, 1'b0, 13'h0000, 8'h00, 2'b01, 1'b0};
        tbl[6]  = '{2'b11, 13'h0010, 13'h0020, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};
        tbl[7]  = '{2'b10, 13'h0010, 13'h0010, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};
        tbl[8]  = '{2'b10, 13'h0010, 13'h0020, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};
        tbl[9]  = '{2'b10, 13'h0010, 13'h0010, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};
        tbl[10] = '{2'b11, 13'h0020, 13'h0010, 1'b0, 13'h0000, 8'h00, 2'b01, 1'b0};
        tbl[11] = '{2'b11, 13'h0020, 13'h0010, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};
        tbl[12] = '{2'b01, 13'h0010, 13'h0000, 1'b1, 13'h0030, 8'hC3, 2'b01, 1'b1};
        tbl[13] = '{2'b10, 13'h0000, 13'h0030, 1'b0, 13'h0000, 8'h00, 2'b10, 1'b0};

        do_reset();

        // Continuous contention straight out of reset: 01,10,01,10,01,10.
        for (int i = 0; i < 6; i++) begin
            tick("fair", 2'b11, 13'h0010, 13'h0020, 1'b0, 13'h0, 8'h0, 1'b0,
                 (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        end

        for (int i = 0; i < 14; i++) begin
            tick($sformatf("vec%0d", i), tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].wreq,
                 tbl[i].wa, tbl[i].wd, 1'b0, tbl[i].gnt, tbl[i].wgnt);
        end

        // Full clear; the clr_start cycle also carries a granted read and write.
        tick("pre_w1", 2'b00, 13'h0, 13'h0, 1'b1, 13'h1FFF, 8'hFF, 1'b0, 2'b00, 1'b1);
        tick("pre_w2", 2'b00, 13'h0, 13'h0, 1'b1, 13'h0000, 8'h3C, 1'b0, 2'b00, 1'b1);
        tick("pre_r1", 2'b01, 13'h0000, 13'h0, 1'b0, 13'h0, 8'h0, 1'b0, 2'b01, 1'b0);
        tick("pre_r2", 2'b10, 13'h0, 13'h1FFF, 1'b0, 13'h0, 8'h0, 1'b0, 2'b10, 1'b0);
        tick("clr1", 2'b01, 13'h0000, 13'h0, 1'b1, 13'h0300, 8'h55, 1'b1, 2'b01, 1'b1);
        run_clear("clear1", -1, -1, 8192, 2'b10);
        tick("post_r1", 2'b01, 13'h0000, 13'h0, 1'b0, 13'h0, 8'h0, 1'b0, 2'b01, 1'b0);
        tick("post_r2", 2'b10, 13'h0, 13'h1FFF, 1'b0, 13'h0, 8'h0, 1'b0, 2'b10, 1'b0);
        tick("post_r3", 2'b01, 13'h0300, 13'h0, 1'b0, 13'h0, 8'h0, 1'b0, 2'b01, 1'b0);

        // clr_start again at busy cycle 100 must not extend the clear.
        tick("clr2", 2'b00, 13'h0, 13'h0, 1'b0, 13'h0, 8'h0, 1'b1, 2'b00, 1'b0);
        run_clear("clear2", 100, -1, 8192, 2'b10);

        // Reset during a clear at busy cycle 50.
        tick("pre_w40", 2'b00, 13'h0, 13'h0, 1'b1, 13'h0040, 8'h11, 1'b0, 2'b00, 1'b1);
        tick("clr3", 2'b00, 13'h0, 13'h0, 1'b0, 13'h0, 8'h0, 1'b1, 2'b00, 1'b0);
        run_clear("clear_rst", -1, 50, 51, 2'b01);
        tick("keep_r40", 2'b10, 13'h0, 13'h0040, 1'b0, 13'h0, 8'h0, 1'b0, 2'b10, 1'b0);
        tick("keep_r200", 2'b01, 13'h0200, 13'h0, 1'b0, 13'h0, 8'h0, 1'b0, 2'b01, 1'b0);
        tick("cleared_r10", 2'b10, 13'h0, 13'h0010, 1'b0, 13'h0, 8'h0, 1'b0, 2'b10, 1'b0);
        tick("flush", 2'b00, 13'h0, 13'h0, 1'b0, 13'h0, 8'h0, 1'b0, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
